hdmi_video_ctrl: RTL and testbench

HDMI_VIDEO_CTRL -- requirements
Module: hdmi_video_ctrl

---
 rtl/hdmi_video_ctrl.sv | 205 ++++++++++++++++++++
 tb/tb_hdmi_video_ctrl.sv | 257 +++++++++++++++++++++++++
 2 files changed

// File: rtl/hdmi_video_ctrl.sv
// rtl/hdmi_video_ctrl.sv - HDMI video timing generator with test pattern / camera source select
module hdmi_video_ctrl #(
  parameter int   H_ACTIVE      = 1280,
  parameter int   H_FP          = 110,
  parameter int   H_SYNC        = 40,
  parameter int   H_BP          = 220,
  parameter int   V_ACTIVE      = 720,
  parameter int   V_FP          = 5,
  parameter int   V_SYNC        = 5,
  parameter int   V_BP          = 20,
  parameter logic HS_POL        = 1'b1,
  parameter logic VS_POL        = 1'b1,
  parameter int   SETTLE_FRAMES = 2
) (
  input  logic        PXLCLK_I,
  input  logic        RST_I,
  input  logic        LOCKED_I,
  input  logic [3:0]  TPG_mode,
  input  logic        SRC_SEL_I,
  input  logic [23:0] CAM_RGB_I,
  input  logic        CAM_VALID_I,
  output logic        VGA_HS,
  output logic        VGA_VS,
  output logic        VGA_DE,
  output logic [23:0] VGA_RGB,
  output logic [11:0] H_CNT,
  output logic [10:0] V_CNT,
  output logic        FRAME_START,
  output logic [3:0]  ACTIVE_MODE,
  output logic        ACTIVE_SRC,
  output logic [1:0]  STATE,
  output logic        UNDERFLOW_O
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam logic [11:0] H_LAST   = 12'(H_TOTAL - 1);
  localparam logic [11:0] H_ACT    = 12'(H_ACTIVE);
  localparam logic [11:0] HS_START = 12'(H_ACTIVE + H_FP);
  localparam logic [11:0] HS_END   = 12'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [10:0] V_LAST   = 11'(V_TOTAL - 1);
  localparam logic [10:0] V_ACT    = 11'(V_ACTIVE);
  localparam logic [10:0] VS_START = 11'(V_ACTIVE + V_FP);
  localparam logic [10:0] VS_END   = 11'(V_ACTIVE + V_FP + V_SYNC);
  localparam logic [3:0]  SETTLE_LAST = 4'(SETTLE_FRAMES - 1);

  typedef enum logic [1:0] {
    S_IDLE   = 2'b00,
    S_SETTLE = 2'b01,
    S_RUN    = 2'b10
  } state_t;

  state_t      state_q, state_d;
  logic        lock_m_q, lock_s_q;
  logic [11:0] h_q, h_d;
  logic [10:0] v_q, v_d;
  logic [3:0]  settle_q, settle_d;
  logic        hs_q, hs_d, vs_q, vs_d, de_q, de_d, fs_q, fs_d;
  logic [23:0] rgb_q, rgb_d;
  logic [11:0] hout_q, hout_d;
  logic [10:0] vout_q, vout_d;
  logic [3:0]  mode_q, mode_d;
  logic        src_q, src_d, uf_q, uf_d;

  logic        run_en, at_origin, active, src_eff;
  logic [3:0]  mode_eff;
  logic [7:0]  gray;
  logic [23:0] tpg;

  // Counters and outputs only move once the FSM has left IDLE and lock is still present,
  // so a falling lock clears everything on the same edge that returns the FSM to IDLE.
  assign run_en    = lock_s_q && (state_q != S_IDLE);
  assign at_origin = (h_q == 12'd0) && (v_q == 11'd0);
  assign active    = (h_q < H_ACT) && (v_q < V_ACT);
  assign mode_eff  = at_origin ? TPG_mode : mode_q;
  assign src_eff   = at_origin ? SRC_SEL_I : src_q;
  assign gray      = h_q[7:0] + v_q[7:0];

  always_comb begin
    tpg = 24'h000000;
    case (mode_eff)
      4'h1: tpg = 24'hFF0000;
      4'h2: tpg = 24'h00FF00;
      4'h3: tpg = 24'h0000FF;
      4'h4: tpg = 24'hFFFFFF;
      4'h5: tpg = {h_q[7:0], 16'h0000};
      4'h6: tpg = {8'h00, h_q[7:0], 8'h00};
      4'h7: tpg = {16'h0000, h_q[7:0]};
      4'h8: tpg = {h_q[7:0], h_q[7:0], h_q[7:0]};
      4'h9: tpg = (h_q[5] ^ v_q[5]) ? 24'hFFFFFF : 24'h000000;
      4'hA: tpg = {gray, gray, gray};
      4'hB: tpg = ((h_q[4:0] == 5'd0) || (v_q[4:0] == 5'd0)) ? 24'hFFFFFF : 24'h000000;
      default: tpg = 24'h000000;
    endcase
  end

  always_comb begin
    state_d  = state_q;
    settle_d = settle_q;
    h_d      = 12'd0;
    v_d      = 11'd0;
    hs_d     = ~HS_POL;
    vs_d     = ~VS_POL;
    de_d     = 1'b0;
    rgb_d    = 24'h000000;
    hout_d   = 12'd0;
    vout_d   = 11'd0;
    fs_d     = 1'b0;
    mode_d   = 4'h0;
    src_d    = 1'b0;
    uf_d     = uf_q;

    case (state_q)
      S_IDLE: if (lock_s_q) state_d = S_SETTLE;
      S_SETTLE: begin
        if (h_q == H_LAST && v_q == V_LAST) begin
          if (settle_q == SETTLE_LAST) begin
            state_d  = S_RUN;
            settle_d = 4'd0;
          end else begin
            settle_d = settle_q + 4'd1;
          end
        end
      end
      S_RUN: ;
      default: state_d = S_IDLE;
    endcase
    if (!lock_s_q) begin
      state_d  = S_IDLE;
      settle_d = 4'd0;
    end

    if (run_en) begin
      h_d    = (h_q == H_LAST) ? 12'd0 : h_q + 12'd1;
      v_d    = (h_q != H_LAST) ? v_q : ((v_q == V_LAST) ? 11'd0 : v_q + 11'd1);
      hs_d   = ((h_q >= HS_START) && (h_q < HS_END)) ? HS_POL : ~HS_POL;
      vs_d   = ((v_q >= VS_START) && (v_q < VS_END)) ? VS_POL : ~VS_POL;
      hout_d = h_q;
      vout_d = v_q;
      fs_d   = at_origin;
      mode_d = mode_eff;
      src_d  = src_eff;
      if (state_q == S_RUN && active) begin
        de_d = 1'b1;
        if (src_eff) begin
          rgb_d = CAM_VALID_I ? CAM_RGB_I : 24'h000000;
          if (!CAM_VALID_I) uf_d = 1'b1;
        end else begin
          rgb_d = tpg;
        end
      end
    end
  end

  always_ff @(posedge PXLCLK_I) begin
    if (RST_I) begin
      state_q  <= S_IDLE;
      lock_m_q <= 1'b0;
      lock_s_q <= 1'b0;
      h_q      <= 12'd0;
      v_q      <= 11'd0;
      settle_q <= 4'd0;
      hs_q     <= ~HS_POL;
      vs_q     <= ~VS_POL;
      de_q     <= 1'b0;
      rgb_q    <= 24'h000000;
      hout_q   <= 12'd0;
      vout_q   <= 11'd0;
      fs_q     <= 1'b0;
      mode_q   <= 4'h0;
      src_q    <= 1'b0;
      uf_q     <= 1'b0;
    end else begin
      state_q  <= state_d;
      lock_m_q <= LOCKED_I;
      lock_s_q <= lock_m_q;
      h_q      <= h_d;
      v_q      <= v_d;
      settle_q <= settle_d;
      hs_q     <= hs_d;
      vs_q     <= vs_d;
      de_q     <= de_d;
      rgb_q    <= rgb_d;
      hout_q   <= hout_d;
      vout_q   <= vout_d;
      fs_q     <= fs_d;
      mode_q   <= mode_d;
      src_q    <= src_d;
      uf_q     <= uf_d;
    end
  end

  assign VGA_HS      = hs_q;
  assign VGA_VS      = vs_q;
  assign VGA_DE      = de_q;
  assign VGA_RGB     = rgb_q;
  assign H_CNT       = hout_q;
  assign V_CNT       = vout_q;
  assign FRAME_START = fs_q;
  assign ACTIVE_MODE = mode_q;
  assign ACTIVE_SRC  = src_q;
  assign STATE       = state_q;
  assign UNDERFLOW_O = uf_q;

endmodule

// File: tb/tb_hdmi_video_ctrl.sv
// tb/tb_hdmi_video_ctrl.sv - randomized scoreboard bench for hdmi_video_ctrl (small timing)
module tb_hdmi_video_ctrl;

  localparam int HA = 8, HT = 16, VA = 4, VT = 8, FRAME = HT * VT, SF = 1;

  logic        clk = 1'b0;
  logic        rst, locked, src_sel, cam_valid;
  logic [3:0]  tpg_mode;
  logic [23:0] cam_rgb;
  logic        vga_hs, vga_vs, vga_de, frame_start, active_src, underflow;
  logic [23:0] vga_rgb;
  logic [11:0] h_cnt;
  logic [10:0] v_cnt;
  logic [3:0]  active_mode;
  logic [1:0]  state;

  always #5 clk = ~clk;

  hdmi_video_ctrl #(
    .H_ACTIVE(8), .H_FP(2), .H_SYNC(2), .H_BP(4),
    .V_ACTIVE(4), .V_FP(1), .V_SYNC(1), .V_BP(2),
    .HS_POL(1'b1), .VS_POL(1'b1), .SETTLE_FRAMES(SF)
  ) dut (
    .PXLCLK_I(clk), .RST_I(rst), .LOCKED_I(locked), .TPG_mode(tpg_mode),
    .SRC_SEL_I(src_sel), .CAM_RGB_I(cam_rgb), .CAM_VALID_I(cam_valid),
    .VGA_HS(vga_hs), .VGA_VS(vga_vs), .VGA_DE(vga_de), .VGA_RGB(vga_rgb),
    .H_CNT(h_cnt), .V_CNT(v_cnt), .FRAME_START(frame_start),
    .ACTIVE_MODE(active_mode), .ACTIVE_SRC(active_src), .STATE(state),
    .UNDERFLOW_O(underflow)
  );

  int n_checks = 0;
  int n_pass   = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
  endtask

  // Reference model: position is a linear pixel index since lock was seen, frames by division.
  bit          lk1, lk2, m_on, snap_src, m_uf;
  int          m_pos;
  logic [3:0]  snap_mode;
  logic        e_hs, e_vs, e_de, e_fs;
  logic [23:0] e_rgb;
  int          e_h, e_v, e_state;

  function automatic logic [23:0] tpg_px(input int mode, input int h, input int v);
    int g;
    g = h % 256;
    case (mode)
      1: return 24'hFF0000;
      2: return 24'h00FF00;
      3: return 24'h0000FF;
      4: return 24'hFFFFFF;
      5: return 24'(g * 65536);
      6: return 24'(g * 256);
      7: return 24'(g);
      8: return 24'(g * 65793);
      9: return ((((h / 32) + (v / 32)) % 2) == 1) ? 24'hFFFFFF : 24'h000000;
      10: return 24'(((h + v) % 256) * 65793);
      11: return ((h % 32 == 0) || (v % 32 == 0)) ? 24'hFFFFFF : 24'h000000;
      default: return 24'h000000;
    endcase
  endfunction

  task automatic model_reset_outputs();
    e_hs = 1'b0; e_vs = 1'b0; e_de = 1'b0; e_fs = 1'b0; e_rgb = 24'h0;
    e_h = 0; e_v = 0; snap_mode = 4'h0; snap_src = 1'b0;
  endtask

  task automatic model_edge();
    int  h, v;
    bit  run, act;
    if (rst) begin
      model_reset_outputs();
      lk1 = 0; lk2 = 0; m_on = 0; m_pos = 0; m_uf = 0; e_state = 0;
      return;
    end
    if (m_on && lk2) begin
      h = m_pos % HT;
      v = (m_pos / HT) % VT;
      run = (m_pos >= FRAME * SF);
      act = (h < HA) && (v < VA);
      if (h == 0 && v == 0) begin
        snap_mode = tpg_mode;
        snap_src  = src_sel;
      end
      e_h = h; e_v = v;
      e_fs = (h == 0 && v == 0);
      e_hs = (h >= 10 && h < 12);
      e_vs = (v == 5);
      e_de = run && act;
      e_rgb = 24'h0;
      if (run && act) begin
        if (snap_src) begin
          e_rgb = cam_valid ? cam_rgb : 24'h0;
          if (!cam_valid) m_uf = 1;
        end else begin
          e_rgb = tpg_px(int'(snap_mode), h, v);
        end
      end
    end else begin
      model_reset_outputs();
    end
    if (!lk2) begin m_on = 0; m_pos = 0; end
    else if (!m_on) begin m_on = 1; m_pos = 0; end
    else m_pos++;
    e_state = !m_on ? 0 : ((m_pos < FRAME * SF) ? 1 : 2);
    lk2 = lk1;
    lk1 = locked;
  endtask

  task automatic chk_all();
    chk("hs", 32'(vga_hs), 32'(e_hs));
    chk("vs", 32'(vga_vs), 32'(e_vs));
    chk("de", 32'(vga_de), 32'(e_de));
    chk("rgb", 32'(vga_rgb), 32'(e_rgb));
    chk("h_cnt", 32'(h_cnt), 32'(e_h));
    chk("v_cnt", 32'(v_cnt), 32'(e_v));
    chk("frame_start", 32'(frame_start), 32'(e_fs));
    chk("active_mode", 32'(active_mode), 32'(snap_mode));
    chk("active_src", 32'(active_src), 32'(snap_src));
    chk("state", 32'(state), 32'(e_state));
    chk("underflow", 32'(underflow), 32'(m_uf));
  endtask

  task automatic step();
    @(posedge clk);
    model_edge();
    @(negedge clk);
    chk_all();
  endtask

  task automatic wait_frame_start(input string tag);
    bit found;
    found = 0;
    for (int i = 0; i < 3 * FRAME && !found; i++) begin
      step();
      if (frame_start) found = 1;
    end
    chk(tag, 32'(found), 32'd1);
  endtask

  initial begin
    int fs_at, de_at, de_cnt, hs_cnt, vs_cnt;
    bit found;
    rst = 1; locked = 0; tpg_mode = 4'h1; src_sel = 0; cam_valid = 1; cam_rgb = 24'h0;
    repeat (3) step();

    // Bring-up: lock at cycle 0, one blank settle frame, then active video from (0,0).
    rst = 0; locked = 1;
    fs_at = -1; de_at = -1;
    for (int i = 0; i < 300 && de_at < 0; i++) begin
      step();
      if (i == 2) chk("settle_by_cycle3", 32'(state), 32'd1);
      if (frame_start && fs_at < 0) fs_at = i;
      if (vga_de && de_at < 0) begin
        de_at = i;
        chk("first_de_h", 32'(h_cnt), 32'd0);
        chk("first_de_v", 32'(v_cnt), 32'd0);
        chk("first_de_state", 32'(state), 32'd2);
      end
    end
    chk("settle_blank_len", 32'(de_at - fs_at), 32'd128);

    repeat (50) step();
    tpg_mode = 4'h3;
    wait_frame_start("wait_fs_mode3");
    chk("mode3_rgb", 32'(vga_rgb), 32'h0000FF);

    tpg_mode = 4'hB;
    wait_frame_start("wait_fs_modeB");
    chk("modeB_origin", 32'(vga_rgb), 32'hFFFFFF);
    repeat (HT + 1) step();
    chk("modeB_h1v1_pos", 32'({h_cnt, 1'b0, v_cnt}), 32'({12'd1, 1'b0, 11'd1}));
    chk("modeB_h1v1", 32'(vga_rgb), 32'h000000);

    wait_frame_start("wait_fs_timing");
    de_cnt = 0; hs_cnt = 0; vs_cnt = 0;
    for (int i = 0; i < FRAME; i++) begin
      if (vga_de) de_cnt++;
      if (vga_hs) begin
        hs_cnt++;
        if (h_cnt != 10 && h_cnt != 11) chk("hs_position", 32'(h_cnt), 32'd10);
      end
      if (vga_vs) vs_cnt++;
      step();
    end
    chk("de_per_frame", 32'(de_cnt), 32'd32);
    chk("hs_per_frame", 32'(hs_cnt), 32'd16);
    chk("vs_per_frame", 32'(vs_cnt), 32'd16);

    repeat (FRAME * 5) begin
      if ($urandom_range(0, 39) == 0) tpg_mode = 4'($urandom);
      cam_rgb = 24'($urandom);
      step();
    end

    repeat ($urandom_range(5, 60)) step();
    locked = 0;
    repeat (3) step();
    chk("lockloss_state", 32'(state), 32'd0);
    chk("lockloss_de", 32'(vga_de), 32'd0);
    chk("lockloss_hcnt", 32'(h_cnt), 32'd0);
    repeat (6) step();
    locked = 1;
    repeat (FRAME * 2 + 10) step();
    chk("relock_run", 32'(state), 32'd2);

    // One dropped camera pixel inside the active region, then random traffic.
    src_sel = 1;
    found = 0;
    for (int i = 0; i < 4 * FRAME && !found; i++) begin
      if (active_src && vga_de && h_cnt < 6) found = 1;
      else step();
    end
    chk("wait_cam_active", 32'(found), 32'd1);
    cam_valid = 0;
    cam_rgb = 24'h123456;
    step();
    chk("cam_drop_rgb", 32'(vga_rgb), 32'h0);
    chk("cam_drop_uf", 32'(underflow), 32'd1);
    cam_valid = 1;
    repeat (FRAME * 4) begin
      cam_rgb = 24'($urandom);
      cam_valid = ($urandom_range(0, 29) != 0);
      step();
    end
    chk("uf_sticky", 32'(underflow), 32'd1);

    cam_valid = 1;
    src_sel = 1'($urandom);
    found = 0;
    for (int i = 0; i < 3 * FRAME && !found; i++) begin
      if (state == 2 && h_cnt == 5 && v_cnt == 2) found = 1;
      else step();
    end
    chk("wait_rst_pos", 32'(found), 32'd1);
    rst = 1;
    step();
    chk("rst_mid_hs", 32'(vga_hs), 32'd0);
    chk("rst_mid_uf", 32'(underflow), 32'd0);
    chk("rst_mid_state", 32'(state), 32'd0);
    rst = 0;
    repeat (FRAME * 2 + 10) begin
      if ($urandom_range(0, 19) == 0) tpg_mode = 4'($urandom);
      step();
    end
    chk("post_rst_run", 32'(state), 32'd2);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
